// File: rtl/mem_pkg.sv
// Shared types for the unified memory port arbiter: FSM states, request
// sources and the default memory depth.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_D  = 1'b1
  } src_t;

  localparam int MEM_WORDS_DEFAULT = 1024;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requests onto one synchronous-write memory port.
// Optional MEM_PORT_ADDR_CHECK_EN adds an addr_err output and range checking.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int AW        = 32,
  parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          if_ack,
  output logic          d_ack,
  output logic [31:0]   instr,
  output logic [31:0]   mdr,
`ifdef MEM_PORT_ADDR_CHECK_EN
  output logic          addr_err,
`endif
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_we,
  input  logic [31:0]   mem_rdata,
  output logic          busy
);

`ifdef MEM_PORT_ADDR_CHECK_EN
  localparam bit CHECK_ON = 1'b1;
`else
  localparam bit CHECK_ON = 1'b0;
`endif
  localparam logic [AW:0] LIMIT = (AW+1)'(MEM_WORDS);

  state_t        state;
  src_t          r_src;
  logic [AW-1:0] r_addr;
  logic          r_we;
  logic [31:0]   r_wdata;
  logic          last_d;
  logic          grant_d;
  logic          addr_bad;

  // Data has priority, but yields once to a waiting fetch after a data grant.
  assign grant_d  = d_req && !(last_d && if_req);
  assign addr_bad = CHECK_ON && ({1'b0, r_addr} >= LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      r_src    <= SRC_IF;
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_wdata  <= '0;
      last_d   <= 1'b0;
      if_ack   <= 1'b0;
      d_ack    <= 1'b0;
      instr    <= '0;
      mdr      <= '0;
`ifdef MEM_PORT_ADDR_CHECK_EN
      addr_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (d_req || if_req) begin
            r_src   <= grant_d ? SRC_D : SRC_IF;
            r_addr  <= grant_d ? d_addr : if_addr;
            r_we    <= grant_d && d_we;
            r_wdata <= grant_d ? d_wdata : 32'h0;
            last_d  <= grant_d;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (!r_we) begin
            if (r_src == SRC_IF) instr <= addr_bad ? 32'h0 : mem_rdata;
            else                 mdr   <= addr_bad ? 32'h0 : mem_rdata;
          end
          if_ack   <= (r_src == SRC_IF);
          d_ack    <= (r_src == SRC_D);
`ifdef MEM_PORT_ADDR_CHECK_EN
          addr_err <= addr_bad;
`endif
          state    <= DONE;
        end
        DONE: begin
          if_ack   <= 1'b0;
          d_ack    <= 1'b0;
`ifdef MEM_PORT_ADDR_CHECK_EN
          addr_err <= 1'b0;
`endif
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Port outputs decode the state register so an async reset drops mem_we at once.
  assign mem_addr  = (state == ACCESS) ? r_addr  : '0;
  assign mem_wdata = (state == ACCESS) ? r_wdata : '0;
  assign mem_we    = (state == ACCESS) && r_we && !addr_bad;
  assign busy      = (state != IDLE);

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter AW, default 32: address width presented to the memory; AW=32 matches the unified memory port.
REQ-002 Parameter MEM_WORDS, default 1024: memory depth in words, used for the range check.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 if_req, if_addr  in  1/AW  fetch request; if_req held high until if_ack; if_addr stable while if_req is high.
REQ-006 d_req, d_we, d_addr, d_wdata  in  1/1/AW/32  data request; held stable until d_ack.
REQ-007 if_ack, d_ack  out  1  one-cycle completion pulses.
REQ-008 instr, mdr  out  32/32  instruction register and memory data register.
REQ-009 mem_addr, mem_wdata, mem_we  out  AW/32/1  unified memory port (word-indexed, synchronous write).
REQ-010 mem_rdata  in  32  combinational read data from the memory.
REQ-011 busy  out  1  high in any state other than IDLE.

Function
REQ-012 FSM states IDLE, ACCESS, DONE; IDLE->ACCESS when any request is pending, ACCESS->DONE unconditionally, DONE->IDLE unconditionally.
REQ-013 In IDLE, the winning request (addr, we, wdata, source) is latched into internal request registers at the clock edge.
REQ-014 Arbitration: data wins over fetch, except when the last grant was data and if_req is high, in which case fetch wins.
REQ-015 mem_addr and mem_wdata are driven from the latched request in ACCESS, and are 0 in IDLE and DONE.
REQ-016 mem_we = 1 only in ACCESS with a latched data write, so exactly one write edge occurs per store.
REQ-017 In ACCESS, a fetch read captures mem_rdata into instr and a data read captures it into mdr at the ACCESS->DONE edge; stores leave both registers unchanged.
REQ-018 In DONE, the matching ack (if_ack or d_ack) is high for exactly one cycle and the captured register is already valid.
REQ-019 Latency: request sampled at edge N, memory access during cycle N+1, ack high in cycle N+2; throughput is one access per 3 cycles.
REQ-020 A request still high in the cycle after its ack is treated as a new request; requesters drop req in the cycle following ack.
REQ-021 Requests arriving during ACCESS or DONE are ignored until IDLE; no request is lost provided req is held.
REQ-022 instr and mdr hold their values between accesses.

Reset
REQ-023 Asserting rst_n=0 forces IDLE immediately; instr, mdr, acks, busy, mem_we, mem_addr, mem_wdata and the last-grant flag all go to 0.
REQ-024 Reset during ACCESS aborts the access; mem_we drops combinationally, so no write commits.

Configuration
REQ-025 Macro MEM_PORT_ADDR_CHECK_EN: when defined, an extra output addr_err (1 bit) is added; a latched address >= MEM_WORDS suppresses mem_we, forces the captured data to 32'h0, and drives addr_err high together with the ack in DONE.
REQ-026 When MEM_PORT_ADDR_CHECK_EN is undefined, addr_err is absent and the address passes through unchecked.

Structure
REQ-027 Shared package mem_pkg holds the FSM state enum (IDLE/ACCESS/DONE), the source enum (SRC_IF/SRC_D) and the constant MEM_WORDS_DEFAULT=1024.
REQ-028 No sub-module; a single flat module, with the memory instantiated alongside it by the parent.

Verification
REQ-029 if_req=1, if_addr=128, memory[128]=32'h00221820 -> if_ack in cycle 2, instr=32'h00221820, mem_we never high.
REQ-030 d_req=1, d_we=1, d_addr=6, d_wdata=32'hDEADBEEF, then a read of address 6 -> mem_we high for exactly one cycle, second d_ack returns mdr=32'hDEADBEEF.
REQ-031 if_req and d_req both high continuously -> grants alternate in the order D, IF, D, IF, with acks every 3 cycles.
REQ-032 Store to address 9 with rst_n pulsed low during ACCESS -> memory[9] keeps 32'd9, all outputs 0, FSM in IDLE.
REQ-033 With MEM_PORT_ADDR_CHECK_EN defined, a store to d_addr=2000 -> no mem_we, and d_ack and addr_err high together; with the macro undefined, the build has no addr_err port.
